mips_mem_responder: RTL and testbench

MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

---
 rtl/mips_mem_responder.sv | 92 +++++++++
 tb/tb_mips_mem_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: word memory that is bulk-loaded by a streaming loader while the
// processor is held in reset, then serves processor reads/writes with range and protocol checks.
module mips_mem_responder #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] writedata,
    output logic [31:0] memdata,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        cpu_reset,
    output logic        fault,
    output logic        proto_err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;
    state_t      r_state;
    logic [AW-1:0] r_ld_ptr;
    logic [31:0] r_mem [DEPTH];
    logic        r_fault;
    logic        r_proto_err;
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;
    logic        w_run;
    logic        w_in_range;
    logic        w_rd_ok;
    logic        w_wr_ok;
    logic        w_oor;
    logic        w_ld_hs;
    logic        w_ld_end;
    assign w_run      = r_state == RUN;
    assign w_in_range = addr < 32'(DEPTH);
    assign w_rd_ok    = w_run & memread & ~memwrite & w_in_range;
    assign w_wr_ok    = w_run & memwrite & ~memread & w_in_range;
    assign w_oor      = w_run & (memread | memwrite) & ~w_in_range;
    assign w_ld_hs    = (r_state == LOAD) & ld_valid;
    assign w_ld_end   = ld_last | (r_ld_ptr == AW'(DEPTH - 1));
    assign memdata    = w_rd_ok ? r_mem[addr[AW-1:0]] : '0;
    assign ld_ready   = r_state == LOAD;
    assign cpu_reset  = r_state == LOAD;
    assign fault      = r_fault;
    assign proto_err  = r_proto_err;
    assign rd_count   = r_rd_count;
    assign wr_count   = r_wr_count;
    // Memory has no reset so that loaded contents survive a processor restart.
    always_ff @(posedge clk) begin
        if (!reset && w_ld_hs)
            r_mem[r_ld_ptr] <= ld_data;
        else if (!reset && w_wr_ok)
            r_mem[addr[AW-1:0]] <= writedata;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= LOAD;
            r_ld_ptr    <= '0;
            r_fault     <= 1'b0;
            r_proto_err <= 1'b0;
            r_rd_count  <= '0;
            r_wr_count  <= '0;
        end else begin
            case (r_state)
                LOAD: if (w_ld_hs) begin
                    if (w_ld_end)
                        r_state <= RUN;
                    else
                        r_ld_ptr <= r_ld_ptr + AW'(1);
                end
                RUN: begin
                    if (memread && memwrite)
                        r_proto_err <= 1'b1;
                    if (w_oor) begin
                        r_fault <= 1'b1;
                        r_state <= HALT;
                    end
                    if (w_rd_ok && r_rd_count != 16'hFFFF)
                        r_rd_count <= r_rd_count + 16'd1;
                    if (w_wr_ok && r_wr_count != 16'hFFFF)
                        r_wr_count <= r_wr_count + 16'd1;
                end
                default: r_state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder: directed and randomized checks of the loader/processor memory
// responder against a per-cycle behavioural model.
module tb_mips_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] memdata;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        cpu_reset;
    logic        fault;
    logic        proto_err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: phase 0=loading, 1=running, 2=halted.
    bit          m_init = 0;
    int          m_phase;
    int          m_ptr;
    bit          m_fault;
    bit          m_proto;
    int          m_rdc;
    int          m_wrc;
    logic [31:0] m_mem [256];
    bit          m_known [256];

    mips_mem_responder #(.DEPTH(256), .AW(8)) dut (
        .clk(clk), .reset(reset), .addr(addr), .memread(memread), .memwrite(memwrite),
        .writedata(writedata), .memdata(memdata), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .cpu_reset(cpu_reset), .fault(fault),
        .proto_err(proto_err), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit rst, input logic [31:0] a, input bit rd, input bit wr,
                       input logic [31:0] wd, input bit lv, input logic [31:0] ld, input bit ll);
        bit rd_ok;
        reset = rst; addr = a; memread = rd; memwrite = wr; writedata = wd;
        ld_valid = lv; ld_data = ld; ld_last = ll;
        #3;
        if (m_init && !rst) begin
            rd_ok = (m_phase == 1) && rd && !wr && (a < 256);
            if (!rd_ok)
                chk("memdata_zero", memdata, 32'h0);
            else if (m_known[a[7:0]])
                chk("memdata", memdata, m_mem[a[7:0]]);
            chk("ld_ready", {31'b0, ld_ready}, {31'b0, m_phase == 0});
            chk("cpu_reset", {31'b0, cpu_reset}, {31'b0, m_phase == 0});
        end
        @(posedge clk);
        if (rst) begin
            m_init = 1; m_phase = 0; m_ptr = 0; m_fault = 0; m_proto = 0; m_rdc = 0; m_wrc = 0;
        end else if (m_phase == 0) begin
            if (lv) begin
                m_mem[m_ptr] = ld; m_known[m_ptr] = 1;
                if (ll || m_ptr == 255) m_phase = 1;
                else m_ptr++;
            end
        end else if (m_phase == 1) begin
            if (rd && wr) m_proto = 1;
            if ((rd || wr) && a >= 256) begin
                m_fault = 1; m_phase = 2;
            end else if (rd && !wr) begin
                if (m_rdc < 65535) m_rdc++;
            end else if (wr && !rd) begin
                m_mem[a[7:0]] = wd; m_known[a[7:0]] = 1;
                if (m_wrc < 65535) m_wrc++;
            end
        end
        #1;
        if (m_init) begin
            chk("fault", {31'b0, fault}, {31'b0, m_fault});
            chk("proto_err", {31'b0, proto_err}, {31'b0, m_proto});
            chk("rd_count", {16'b0, rd_count}, 32'(m_rdc));
            chk("wr_count", {16'b0, wr_count}, 32'(m_wrc));
            chk("ld_ready_post", {31'b0, ld_ready}, {31'b0, m_phase == 0});
        end
    endtask

    task automatic idle();            cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_reset();        cyc(1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic load(input logic [31:0] d, input bit last); cyc(0, 0, 0, 0, 0, 1, d, last); endtask
    task automatic rd(input logic [31:0] a);                    cyc(0, a, 1, 0, 0, 0, 0, 0); endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d); cyc(0, a, 0, 1, d, 0, 0, 0); endtask

    initial begin
        logic [31:0] saved;
        @(posedge clk); #1;
        do_reset();
        chk("reset_ld_ready", {31'b0, ld_ready}, 32'h1);
        chk("reset_cpu_reset", {31'b0, cpu_reset}, 32'h1);
        chk("reset_memdata", memdata, 32'h0);
        // Load four words with a bubble, ld_last on the fourth.
        load(32'hA000_0000, 0);
        load(32'hA000_0001, 0);
        idle();
        load(32'hA000_0002, 0);
        load(32'hA000_0003, 1);
        chk("run_cpu_reset", {31'b0, cpu_reset}, 32'h0);
        rd(2);
        addr = 2; memread = 1; #1;
        chk("read_a2", memdata, 32'hA000_0002);
        chk("rd_count_1", {16'b0, rd_count}, 32'h1);
        wr(5, 32'hDEADBEEF);
        rd(5);
        chk("wr_count_1", {16'b0, wr_count}, 32'h1);
        wr(7, 32'h7777_0007);
        cyc(0, 7, 1, 1, 32'h1234_5678, 0, 0, 0);
        chk("both_proto", {31'b0, proto_err}, 32'h1);
        chk("both_still_run", {31'b0, ld_ready}, 32'h0);
        rd(7);
        addr = 7; memread = 1; memwrite = 0; #1;
        chk("mem7_kept", memdata, 32'h7777_0007);
        rd(0); rd(1); rd(3);
        do_reset();
        chk("midrun_rdc", {16'b0, rd_count}, 32'h0);
        chk("midrun_proto", {31'b0, proto_err}, 32'h0);
        chk("midrun_cpu_reset", {31'b0, cpu_reset}, 32'h1);
        load(32'hB000_0000, 1);
        rd(3);
        addr = 3; memread = 1; #1;
        chk("retained_3", memdata, 32'hA000_0003);
        // Out-of-range read halts; a later write must not land.
        rd(256);
        chk("oor_fault", {31'b0, fault}, 32'h1);
        wr(3, 32'hBAD0_0003);
        rd(3);
        do_reset();
        load(32'hC000_0000, 1);
        rd(3);
        addr = 3; memread = 1; #1;
        chk("halt_no_write", memdata, 32'hA000_0003);
        // Full load of 256 words with no ld_last.
        do_reset();
        for (int i = 0; i < 256; i++) load(32'hF000_0000 + 32'(i), 0);
        chk("full_ld_ready", {31'b0, ld_ready}, 32'h0);
        rd(255);
        addr = 255; memread = 1; #1;
        chk("full_last", memdata, 32'hF000_00FF);
        // Randomized sessions against the model.
        for (int s = 0; s < 6; s++) begin
            int nload;
            do_reset();
            nload = $urandom_range(1, 20);
            for (int i = 0; i < nload; i++) begin
                if ($urandom_range(0, 3) == 0) idle();
                load($urandom, i == nload - 1);
            end
            for (int k = 0; k < 300; k++) begin
                int sel;
                logic [31:0] a;
                sel = $urandom_range(0, 99);
                a = (sel < 3) ? 32'(256 + $urandom_range(0, 1000)) : 32'($urandom_range(0, 15));
                if (sel < 6) cyc(0, a, 1, 1, $urandom, $urandom_range(0, 1), $urandom, 1);
                else if (sel < 50) cyc(0, a, 1, 0, 0, $urandom_range(0, 1), $urandom, 1);
                else if (sel < 85) cyc(0, a, 0, 1, $urandom, $urandom_range(0, 1), $urandom, 0);
                else idle();
            end
        end
        saved = 32'(n_fail);
        $display("[TB] %0d tests run, %0d failed", n_tests, saved);
        $finish;
    end
endmodule
